// File: rtl/madd_sweep_checker.sv
// ============================================================================
// Module   : madd_sweep_checker
// Purpose  : Exhaustive 64-vector sweep of the approximate 3x2-bit adder,
//            accumulating error statistics against threshold ET.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module madd_sweep_checker #(
    parameter int SETTLE = 1,
    parameter int ET     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    output logic [5:0] op_o,
    input  logic [3:0] approx_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] max_err_o,
    output logic [6:0] err_cnt_o,
    output logic [9:0] sum_err_o,
    output logic [5:0] first_fail_o,
    output logic       first_fail_vld_o
);

    localparam logic [2:0] C_SETTLE_LAST = 3'(SETTLE - 1);
    localparam logic [3:0] C_ET          = 4'(ET);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [2:0] settle_q, settle_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] max_err_q, max_err_d;
    logic [6:0] err_cnt_q, err_cnt_d;
    logic [9:0] sum_err_q, sum_err_d;
    logic [5:0] ff_q, ff_d;
    logic       ff_vld_q, ff_vld_d;

    logic [3:0]        exact;
    logic signed [4:0] diff;
    logic signed [4:0] neg_diff;
    logic [3:0]        err;

    // Exact reference sum and absolute error of the currently driven vector
    always_comb begin
        exact    = {2'b00, idx_q[1:0]} + {2'b00, idx_q[3:2]} + {2'b00, idx_q[5:4]};
        diff     = $signed({1'b0, approx_i}) - $signed({1'b0, exact});
        neg_diff = -diff;
        err      = diff[4] ? neg_diff[3:0] : diff[3:0];
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        settle_d  = settle_q;
        max_err_d = max_err_q;
        err_cnt_d = err_cnt_q;
        sum_err_d = sum_err_q;
        ff_d      = ff_q;
        ff_vld_d  = ff_vld_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_DRIVE;
                    idx_d     = 6'd0;
                    settle_d  = 3'd0;
                    max_err_d = 4'd0;
                    err_cnt_d = 7'd0;
                    sum_err_d = 10'd0;
                    ff_d      = 6'd0;
                    ff_vld_d  = 1'b0;
                end
            end
            S_DRIVE: begin
                if (settle_q == C_SETTLE_LAST) begin
                    state_d  = S_SAMPLE;
                    settle_d = 3'd0;
                end else begin
                    settle_d = settle_q + 3'd1;
                end
            end
            S_SAMPLE: begin
                if (err > max_err_q) begin
                    max_err_d = err;
                end
                err_cnt_d = err_cnt_q + {6'd0, (err != 4'd0)};
                sum_err_d = sum_err_q + {6'd0, err};
                if ((err > C_ET) && !ff_vld_q) begin
                    ff_d     = idx_q;
                    ff_vld_d = 1'b1;
                end
                if (idx_q == 6'd63) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 6'd0;
            settle_q  <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            max_err_q <= 4'd0;
            err_cnt_q <= 7'd0;
            sum_err_q <= 10'd0;
            ff_q      <= 6'd0;
            ff_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            settle_q  <= settle_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            max_err_q <= max_err_d;
            err_cnt_q <= err_cnt_d;
            sum_err_q <= sum_err_d;
            ff_q      <= ff_d;
            ff_vld_q  <= ff_vld_d;
        end
    end

    assign op_o             = idx_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = (max_err_q <= C_ET);
    assign max_err_o        = max_err_q;
    assign err_cnt_o        = err_cnt_q;
    assign sum_err_o        = sum_err_q;
    assign first_fail_o     = ff_q;
    assign first_fail_vld_o = ff_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_madd_sweep_checker.sv
// ============================================================================
// Module   : tb_madd_sweep_checker
// Purpose  : Directed self-checking bench for madd_sweep_checker (SETTLE 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_madd_sweep_checker;

    logic       clk;
    logic       rst_n;
    logic       start_i, start3;
    logic [1:0] mode;
    logic [5:0] op_o, op3;
    logic [3:0] approx_i, approx3;
    logic       busy_o, done_o, pass_o, ff_vld;
    logic [3:0] max_err_o;
    logic [6:0] err_cnt_o;
    logic [9:0] sum_err_o;
    logic [5:0] ff_o;
    logic       busy3, done3, pass3, ff_vld3;
    logic [3:0] max_err3;
    logic [6:0] err_cnt3;
    logic [9:0] sum_err3;
    logic [5:0] ff3;

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder models: 0 exact, 1 tied to zero, 2 exact+4, 3 exact+5
    always_comb begin
        logic [3:0] ex;
        ex = {2'b00, op_o[1:0]} + {2'b00, op_o[3:2]} + {2'b00, op_o[5:4]};
        approx_i = ex;
        case (mode)
            2'd1:    approx_i = 4'd0;
            2'd2:    approx_i = ex + 4'd4;
            2'd3:    approx_i = ex + 4'd5;
            default: approx_i = ex;
        endcase
    end

    assign approx3 = {2'b00, op3[1:0]} + {2'b00, op3[3:2]} + {2'b00, op3[5:4]};

    madd_sweep_checker #(.SETTLE(1), .ET(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_o(op_o), .approx_i(approx_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .max_err_o(max_err_o),
        .err_cnt_o(err_cnt_o), .sum_err_o(sum_err_o), .first_fail_o(ff_o),
        .first_fail_vld_o(ff_vld)
    );

    madd_sweep_checker #(.SETTLE(3), .ET(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_i(start3), .op_o(op3), .approx_i(approx3),
        .busy_o(busy3), .done_o(done3), .pass_o(pass3), .max_err_o(max_err3),
        .err_cnt_o(err_cnt3), .sum_err_o(sum_err3), .first_fail_o(ff3),
        .first_fail_vld_o(ff_vld3)
    );

    // Start a SETTLE=1 sweep and wait for done; dcyc = edges after edge 0
    task automatic run_sweep1(input bit pulse_start, output int dcyc);
        int cyc;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || op_o !== 6'd0) begin
            failures++;
            $display("FAIL sweep_start busy=%0b op=%0d required busy=1 op=0", busy_o, op_o);
        end
        cyc  = 0;
        dcyc = -1;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start_i = pulse_start && (cyc == 10 || cyc == 60);
            if (cyc == 2) begin
                checks++;
                if (op_o !== 6'd1) begin
                    failures++;
                    $display("FAIL op_step op=%0d required 1 after edge 2", op_o);
                end
            end
            if (done_o === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
        start_i = 1'b0;
        checks++;
        if (dcyc != 128) begin
            failures++;
            $display("FAIL done_timing edge=%0d required 128", dcyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; start3 = 1'b0; mode = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({op_o, busy_o, done_o, pass_o} !== {6'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_ctrl op=%0d busy=%0b done=%0b pass=%0b required 0 0 0 1",
                     op_o, busy_o, done_o, pass_o);
        end
        checks++;
        if ({max_err_o, err_cnt_o, sum_err_o, ff_o, ff_vld} !== 28'd0) begin
            failures++;
            $display("FAIL reset_stats max=%0d cnt=%0d sum=%0d ff=%0d vld=%0b required all 0",
                     max_err_o, err_cnt_o, sum_err_o, ff_o, ff_vld);
        end
    endtask

    task automatic check_stats(input string nm, input logic [3:0] mx, input logic [6:0] cnt,
                               input logic [9:0] sm, input logic ps, input logic [5:0] ff,
                               input logic vld);
        checks++;
        if (max_err_o !== mx || err_cnt_o !== cnt || sum_err_o !== sm || pass_o !== ps) begin
            failures++;
            $display("FAIL %s_stats max=%0d cnt=%0d sum=%0d pass=%0b required %0d %0d %0d %0b",
                     nm, max_err_o, err_cnt_o, sum_err_o, pass_o, mx, cnt, sm, ps);
        end
        checks++;
        if (ff_vld !== vld || (vld && ff_o !== ff)) begin
            failures++;
            $display("FAIL %s_first_fail vld=%0b idx=%0d required vld=%0b idx=%0d",
                     nm, ff_vld, ff_o, vld, ff);
        end
    endtask

    task automatic test_exact();
        int d;
        mode = 2'd0;
        run_sweep1(1'b0, d);
        check_stats("exact", 4'd0, 7'd0, 10'd0, 1'b1, 6'd0, 1'b0);
        checks++;
        if (busy_o !== 1'b0 || op_o !== 6'd63) begin
            failures++;
            $display("FAIL done_state busy=%0b op=%0d required busy=0 op=63", busy_o, op_o);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse done=%0b required 0 one cycle later", done_o);
        end
    endtask

    task automatic test_zero();
        int d;
        mode = 2'd1;
        run_sweep1(1'b0, d);
        check_stats("zero", 4'd9, 7'd63, 10'd288, 1'b0, 6'd11, 1'b1);
    endtask

    task automatic test_plus4();
        int d;
        mode = 2'd2;
        run_sweep1(1'b0, d);
        check_stats("plus4", 4'd4, 7'd64, 10'd256, 1'b1, 6'd0, 1'b0);
    endtask

    task automatic test_plus5();
        int d;
        mode = 2'd3;
        run_sweep1(1'b0, d);
        check_stats("plus5", 4'd5, 7'd64, 10'd320, 1'b0, 6'd0, 1'b1);
    endtask

    task automatic test_start_ignored();
        int d;
        int bad;
        mode = 2'd1;
        run_sweep1(1'b1, d);
        check_stats("ignored", 4'd9, 7'd63, 10'd288, 1'b0, 6'd11, 1'b1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_o !== 1'b0 || busy_o !== 1'b0 || op_o !== 6'd63 || max_err_o !== 4'd9 ||
                err_cnt_o !== 7'd63 || sum_err_o !== 10'd288 || ff_o !== 6'd11 || ff_vld !== 1'b1)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_idle changed_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        int ndone;
        mode = 2'd1;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({op_o, busy_o, done_o, pass_o, max_err_o, err_cnt_o, sum_err_o, ff_o, ff_vld} !==
            {6'd0, 1'b0, 1'b0, 1'b1, 28'd0}) begin
            failures++;
            $display("FAIL mid_reset op=%0d busy=%0b max=%0d cnt=%0d sum=%0d vld=%0b required reset values",
                     op_o, busy_o, max_err_o, err_cnt_o, sum_err_o, ff_vld);
        end
        ndone = 0;
        repeat (200) begin
            @(negedge clk);
            if (done_o !== 1'b0 || busy_o !== 1'b0) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL mid_reset_quiet activity_cycles=%0d required 0", ndone);
        end
        mode = 2'd0;
        run_sweep1(1'b0, d);
        check_stats("after_reset", 4'd0, 7'd0, 10'd0, 1'b1, 6'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int d;
        mode = 2'd1;
        run_sweep1(1'b0, d);
        start_i = 1'b1;
        mode    = 2'd0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle busy=%0b done=%0b required 0 0", busy_o, done_o);
        end
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || op_o !== 6'd0 || max_err_o !== 4'd0 || ff_vld !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart busy=%0b op=%0d max=%0d vld=%0b required 1 0 0 0",
                     busy_o, op_o, max_err_o, ff_vld);
        end
        d = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                d = c;
                break;
            end
        end
        checks++;
        if (d != 128) begin
            failures++;
            $display("FAIL b2b_done edge=%0d required 128", d);
        end
        check_stats("b2b", 4'd0, 7'd0, 10'd0, 1'b1, 6'd0, 1'b0);
    endtask

    task automatic test_settle3();
        int d;
        int opbad;
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        d = -1;
        opbad = 0;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (c == 3 && op3 !== 6'd0) opbad++;
            if (c == 4 && op3 !== 6'd1) opbad++;
            if (c == 7 && op3 !== 6'd1) opbad++;
            if (c == 8 && op3 !== 6'd2) opbad++;
            if (done3 === 1'b1) begin
                d = c;
                break;
            end
        end
        checks++;
        if (opbad != 0) begin
            failures++;
            $display("FAIL settle3_op_step wrong_samples=%0d required 0", opbad);
        end
        checks++;
        if (d != 256) begin
            failures++;
            $display("FAIL settle3_done edge=%0d required 256", d);
        end
        checks++;
        if (max_err3 !== 4'd0 || err_cnt3 !== 7'd0 || sum_err3 !== 10'd0 || pass3 !== 1'b1 ||
            ff_vld3 !== 1'b0 || busy3 !== 1'b0 || ff3 !== 6'd0) begin
            failures++;
            $display("FAIL settle3_stats max=%0d cnt=%0d sum=%0d pass=%0b vld=%0b required 0 0 0 1 0",
                     max_err3, err_cnt3, sum_err3, pass3, ff_vld3);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_exact();
        test_zero();
        test_plus4();
        test_plus5();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_settle3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
